// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - store types, FSM encodings and lane-mask helpers
package store_align_unit_pkg;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_RSVD = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_FIRST  = 2'b01;
    localparam logic [1:0] S_SECOND = 2'b10;

    // Byte-enable mask over two adjacent words: low nibble is the addressed word.
    function automatic logic [7:0] lane_mask8(input logic [1:0] st_type, input logic [1:0] off);
        logic [7:0] base;
        case (st_type)
            ST_SB:   base = 8'h01;
            ST_SH:   base = 8'h03;
            ST_SW:   base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic crosses_word(input logic [1:0] st_type, input logic [1:0] off);
        logic [7:0] m8;
        m8 = lane_mask8(st_type, off);
        return |m8[7:4];
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// rtl/store_align_unit_if.sv - request and memory-write handshake bundle
interface store_align_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    logic              misalign_err;

    modport master (
        output req_valid, req_type, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err
    );
endinterface

// File: rtl/store_align_unit_lane_gen.sv
// rtl/store_align_unit_lane_gen.sv - byte enables and lane-shifted data for one write beat
module store_lane_gen
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  st_type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    input  logic        second_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);
    logic [7:0] m8;
    logic [5:0] shamt;

    always_comb begin
        m8 = lane_mask8(st_type_i, off_i);
        if (second_i) begin
            // Spill-over bytes land in the low lanes of the next word.
            be_o    = m8[7:4];
            shamt   = 6'd32 - {1'b0, off_i, 3'b000};
            wdata_o = data_i >> shamt;
        end else begin
            be_o    = m8[3:0];
            shamt   = {1'b0, off_i, 3'b000};
            wdata_o = data_i << shamt;
        end
    end
endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store request to word-aligned memory writes; MISALIGN_SPLIT_EN enables split of crossing stores
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    store_align_unit_if.slave  bus
);
    logic [1:0]        state_q, state_d;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              err_q, err_d;

    logic              mem_valid, second, cross_q, cross_in, type_ok;
    logic              beat_done, last_beat, req_ready, accept, launch;
    logic [ADDR_W-1:0] word_addr, beat_addr;
    logic [3:0]        be_raw;
    logic [31:0]       wdata_raw;

    assign mem_valid = (state_q != S_IDLE);
    assign second    = (state_q == S_SECOND);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign beat_addr = second ? word_addr + ADDR_W'(4) : word_addr;

    store_lane_gen u_lane_gen (
        .st_type_i (type_q),
        .off_i     (addr_q[1:0]),
        .data_i    (data_q),
        .second_i  (second),
        .be_o      (be_raw),
        .wdata_o   (wdata_raw)
    );

    always_comb begin
        cross_q   = crosses_word(type_q, addr_q[1:0]);
        cross_in  = crosses_word(bus.req_type, bus.req_addr[1:0]);
        type_ok   = (bus.req_type != ST_RSVD);
        beat_done = mem_valid & bus.mem_ready;
        last_beat = beat_done & (second | !cross_q);
        req_ready = (state_q == S_IDLE) | last_beat;
        accept    = bus.req_valid & req_ready;
`ifdef MISALIGN_SPLIT_EN
        launch    = type_ok;
        err_d     = 1'b0;
`else
        launch    = type_ok & !cross_in;
        err_d     = accept & type_ok & cross_in;
`endif
        state_d = state_q;
        if (last_beat) begin
            state_d = S_IDLE;
        end
`ifdef MISALIGN_SPLIT_EN
        else if (beat_done) begin
            state_d = S_SECOND;
        end
`endif
        // A request taken on the final beat's edge starts its first beat immediately.
        if (accept) begin
            state_d = launch ? S_FIRST : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= ST_SB;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                type_q <= bus.req_type;
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.mem_valid    = mem_valid;
    assign bus.mem_addr     = mem_valid ? beat_addr : '0;
    assign bus.mem_be       = mem_valid ? be_raw : 4'b0000;
    assign bus.mem_wdata    = mem_valid ? wdata_raw : 32'h0;
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - scoreboard bench for store_align_unit
module tb_store_align_unit;
    import store_align_unit_pkg::*;

    localparam int ADDR_W = 32;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_align_unit_if #(.ADDR_W(ADDR_W)) bus ();
    store_align_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cycles = 0;
    beat_t hold;
    bit    holding = 1'b0;

    always @(posedge clk) cycles <= cycles + 1;

    function automatic int type_size(input logic [1:0] t);
        case (t)
            ST_SB:   return 1;
            ST_SH:   return 2;
            ST_SW:   return 4;
            default: return 0;
        endcase
    endfunction

    // Places each store byte at its own address, then groups bytes by word.
    task automatic push_expected(input logic [1:0] t, input logic [31:0] a,
                                 input logic [31:0] d, output bit crossing);
        beat_t       b0, b1;
        logic [31:0] ba, w0;
        int          sz, lane;
        sz = type_size(t);
        w0 = a & 32'hFFFF_FFFC;
        b0.addr = w0;         b0.be = 4'b0; b0.data = 32'h0;
        b1.addr = w0 + 32'd4; b1.be = 4'b0; b1.data = 32'h0;
        for (int k = 0; k < sz; k++) begin
            ba   = a + k;
            lane = int'(ba[1:0]);
            if ((ba & 32'hFFFF_FFFC) == w0) begin
                b0.be[lane] = 1'b1;
                b0.data[8*lane +: 8] = d[8*k +: 8];
            end else begin
                b1.be[lane] = 1'b1;
                b1.data[8*lane +: 8] = d[8*k +: 8];
            end
        end
        crossing = (b1.be != 4'b0);
        if (sz > 0 && (!crossing || SPLIT)) exp_q.push_back(b0);
        if (crossing && SPLIT) exp_q.push_back(b1);
    endtask

    always @(negedge clk) begin
        beat_t       e;
        logic [31:0] m;
        if (!rst_n) begin
            holding = 1'b0;
        end else if (bus.mem_valid) begin
            if (holding) begin
                n_checks++;
                if (bus.mem_addr !== hold.addr || bus.mem_be !== hold.be || bus.mem_wdata !== hold.data) begin
                    n_fail++;
                    $display("FAIL stall_stable: got addr=%h be=%b wdata=%h, held addr=%h be=%b wdata=%h",
                             bus.mem_addr, bus.mem_be, bus.mem_wdata, hold.addr, hold.be, hold.data);
                end
            end
            if (bus.mem_ready) begin
                holding = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got addr=%h be=%b, expected no beat", bus.mem_addr, bus.mem_be);
                end else begin
                    e = exp_q.pop_front();
                    m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                    if (bus.mem_addr !== e.addr) begin
                        n_fail++;
                        $display("FAIL beat_addr: got %h expected %h", bus.mem_addr, e.addr);
                    end
                    n_checks++;
                    if (bus.mem_be !== e.be) begin
                        n_fail++;
                        $display("FAIL beat_be: got %b expected %b", bus.mem_be, e.be);
                    end
                    n_checks++;
                    if ((bus.mem_wdata & m) !== (e.data & m)) begin
                        n_fail++;
                        $display("FAIL beat_wdata: got %h expected %h (mask %h)", bus.mem_wdata, e.data, m);
                    end
                end
            end else begin
                holding   = 1'b1;
                hold.addr = bus.mem_addr;
                hold.be   = bus.mem_be;
                hold.data = bus.mem_wdata;
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, output bit crossing);
        int cyc = 0;
        bit done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_data  = d;
        while (!done && cyc < 50) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.req_valid = 1'b0;
        bus.req_type  = 2'($urandom);
        bus.req_addr  = $urandom;
        bus.req_data  = $urandom;
        crossing = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", bus.req_ready, cyc);
        end else begin
            push_expected(t, a, d, crossing);
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.mem_valid === 1'b1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_type = ST_SB; bus.req_addr = '0; bus.req_data = '0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b expected 0", bus.mem_valid); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        n_checks++; if (bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be: got %b expected 0", bus.mem_be); end
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign_err: got %b expected 0", bus.misalign_err); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_sw();
        bit c;
        bus.mem_ready = 1'b1;
        send(ST_SW, 32'h100, 32'hDEAD_BEEF, c);
        @(negedge clk);
        n_checks++;
        if (bus.mem_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL aligned_sw_ready: got mem_valid=%b req_ready=%b expected 1/1", bus.mem_valid, bus.req_ready);
        end
        drain();
    endtask

    task automatic test_sb_offsets();
        bit c;
        bus.mem_ready = 1'b1;
        for (int off = 0; off < 4; off++)
            send(ST_SB, 32'h200 + off, {$urandom_range(0, 32'hFF_FFFF), 8'hA5} & 32'hFFFF_FFFF, c);
        drain();
    endtask

    task automatic test_cross_sh();
        bit c;
        bus.mem_ready = 1'b1;
        send(ST_SH, 32'h303, 32'hBEEF_1234, c);
        @(negedge clk);
        if (SPLIT) begin
            n_checks++;
            if (bus.req_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL cross_sh_beat1: got req_ready=%b mem_valid=%b expected 0/1", bus.req_ready, bus.mem_valid);
            end
            n_checks++;
            if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL cross_sh_err: got %b expected 0", bus.misalign_err); end
        end else begin
            n_checks++;
            if (bus.misalign_err !== 1'b1 || bus.mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_pulse: got err=%b mem_valid=%b expected 1/0", bus.misalign_err, bus.mem_valid);
            end
            @(negedge clk);
            n_checks++;
            if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_width: got err=%b expected 0", bus.misalign_err); end
        end
        drain();
        send(ST_SW, 32'h504, 32'h5566_7788, c);
        drain();
    endtask

    task automatic test_backpressure();
        bit c;
        int nbeats;
        bus.mem_ready = 1'b0;
        send(ST_SW, 32'h401, 32'h1122_3344, c);
        nbeats = c ? (SPLIT ? 2 : 0) : 1;
        for (int b = 0; b < nbeats; b++) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid beat%0d: got %b expected 1", b, bus.mem_valid); end
            @(posedge clk); #1;
            bus.mem_ready = 1'b1;
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
        end
        bus.mem_ready = 1'b1;
        drain();
    endtask

    task automatic test_wrap_reset();
        bit c;
        bus.mem_ready = 1'b1;
        send(ST_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, c);
        drain();
        bus.mem_ready = 1'b0;
        send(ST_SW, 32'h600, 32'h0BAD_F00D, c);
        @(negedge clk);
        n_checks++;
        if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", bus.mem_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got mem_valid=%b req_ready=%b expected 0/1", bus.mem_valid, bus.req_ready);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got mem_valid=%b expected 0", bus.mem_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit c;
        int t0;
        bus.mem_ready = 1'b1;
        t0 = cycles;
        for (int i = 0; i < 4; i++) send(ST_SW, 32'h700 + 4*i, $urandom, c);
        n_checks++;
        if (cycles - t0 !== 4) begin n_fail++; $display("FAIL back_to_back_rate: got %0d cycles expected 4", cycles - t0); end
        drain();
        send(ST_RSVD, 32'h800, 32'hFFFF_FFFF, c);
        @(negedge clk);
        n_checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_type: got mem_valid=%b req_ready=%b expected 0/1", bus.mem_valid, bus.req_ready);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_aligned_sw();
        test_sb_offsets();
        test_cross_sh();
        test_backpressure();
        test_wrap_reset();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_beats: got %0d expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
